k12a_mem_initiator: RTL and testbench

//  Bus-master sequencer for the k12a memory bus: drives mem_enable, mem_mode, async_write, addr_bus, data_bus.

---
 rtl/k12a_mem_initiator.sv | 221 ++++++++++++++++++++++
 tb/tb_k12a_mem_initiator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/k12a_mem_initiator.sv
// k12a memory-bus initiator: turns 8/16-bit core loads/stores into timed byte
// cycles on the shared tristate address/data buses.
package k12a_mem_pkg;
  typedef enum logic {MEM_MODE_READ = 1'b0, MEM_MODE_WRITE = 1'b1} mem_mode_t;
endpackage

module k12a_mem_initiator
  import k12a_mem_pkg::*;
#(
  parameter int unsigned READ_CYCLES   = 2,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        mem_enable,
  output mem_mode_t   mem_mode,
  output logic        async_write,
  inout  wire  [15:0] addr_bus,
  inout  wire  [7:0]  data_bus
);

  localparam logic [3:0] READ_LEN   = READ_CYCLES[3:0];
  localparam logic [3:0] SETUP_LEN  = SETUP_CYCLES[3:0];
  localparam logic [3:0] STROBE_LEN = STROBE_CYCLES[3:0];
  localparam logic [3:0] HOLD_LEN   = HOLD_CYCLES[3:0];

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD        = 3'd1,
    ST_WR_SETUP  = 3'd2,
    ST_WR_STROBE = 3'd3,
    ST_WR_HOLD   = 3'd4,
    ST_GAP       = 3'd5,
    ST_RESP      = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  state_t      after_byte_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nx_s;
  logic        last_s;
  logic        accept_s;
  logic        wr_r;
  logic        wide_r;
  logic        byte_idx_r;
  logic [15:0] cur_addr_r;
  logic [15:0] wdata_r;
  logic [15:0] rdata_r;
  logic [15:0] rdata_nx_s;
  logic        en_nx_s;
  logic        wr_phase_nx_s;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [15:0] rsp_rdata_r;
  logic        mem_enable_r;
  mem_mode_t   mem_mode_r;
  logic        async_write_r;
  logic        addr_oe_r;
  logic        data_oe_r;
  logic [7:0]  cur_byte_s;

  assign last_s       = (cnt_r == 4'd1);
  assign accept_s     = (state_r == ST_IDLE) && req_valid;
  assign after_byte_s = (wide_r && !byte_idx_r) ? ST_GAP : ST_RESP;
  assign cur_byte_s   = byte_idx_r ? wdata_r[15:8] : wdata_r[7:0];

  // Next-state, phase-counter reload and read-byte capture.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    rdata_nx_s = rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nx_s = req_write ? ST_WR_SETUP : ST_RD;
          cnt_nx_s   = req_write ? SETUP_LEN : READ_LEN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (last_s) begin
          state_nx_s = after_byte_s;
          cnt_nx_s   = 4'd0;
          if (byte_idx_r) begin
            rdata_nx_s[15:8] = data_bus;
          end else begin
            rdata_nx_s[7:0] = data_bus;
          end
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      ST_WR_SETUP: begin
        if (last_s) begin
          state_nx_s = ST_WR_STROBE;
          cnt_nx_s   = STROBE_LEN;
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      ST_WR_STROBE: begin
        if (last_s) begin
          state_nx_s = ST_WR_HOLD;
          cnt_nx_s   = HOLD_LEN;
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      ST_WR_HOLD: begin
        if (last_s) begin
          state_nx_s = after_byte_s;
          cnt_nx_s   = 4'd0;
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      ST_GAP: begin
        state_nx_s = wr_r ? ST_WR_SETUP : ST_RD;
        cnt_nx_s   = wr_r ? SETUP_LEN : READ_LEN;
      end
      ST_RESP: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 4'd0;
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // Bus qualifiers for the state being entered, so outputs can be registered.
  always_comb begin
    en_nx_s       = 1'b0;
    wr_phase_nx_s = 1'b0;
    case (state_nx_s)
      ST_RD: begin
        en_nx_s = 1'b1;
      end
      ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD: begin
        en_nx_s       = 1'b1;
        wr_phase_nx_s = 1'b1;
      end
      default: begin
        en_nx_s       = 1'b0;
        wr_phase_nx_s = 1'b0;
      end
    endcase
  end

  // Sequencer state, request latch, address advance and registered bus outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 4'd0;
      wr_r          <= 1'b0;
      wide_r        <= 1'b0;
      byte_idx_r    <= 1'b0;
      cur_addr_r    <= 16'd0;
      wdata_r       <= 16'd0;
      rdata_r       <= 16'd0;
      req_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= 16'd0;
      mem_enable_r  <= 1'b0;
      mem_mode_r    <= MEM_MODE_READ;
      async_write_r <= 1'b0;
      addr_oe_r     <= 1'b0;
      data_oe_r     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      if (accept_s) begin
        wr_r       <= req_write;
        wide_r     <= req_wide;
        cur_addr_r <= req_addr;
        wdata_r    <= req_wdata;
        byte_idx_r <= 1'b0;
        rdata_r    <= 16'd0;
      end else if (state_r == ST_GAP) begin
        // 16-bit wrap of the high-byte address is intentional.
        cur_addr_r <= cur_addr_r + 16'd1;
        byte_idx_r <= 1'b1;
      end else begin
        rdata_r <= rdata_nx_s;
      end
      req_ready_r   <= (state_nx_s == ST_IDLE);
      mem_enable_r  <= en_nx_s;
      addr_oe_r     <= en_nx_s;
      data_oe_r     <= wr_phase_nx_s;
      mem_mode_r    <= wr_phase_nx_s ? MEM_MODE_WRITE : MEM_MODE_READ;
      async_write_r <= (state_nx_s == ST_WR_STROBE);
      rsp_valid_r   <= (state_nx_s == ST_RESP);
      if (state_nx_s == ST_RESP) begin
        rsp_rdata_r <= wr_r ? 16'd0 : rdata_nx_s;
      end
    end
  end

  assign req_ready   = req_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign mem_enable  = mem_enable_r;
  assign mem_mode    = mem_mode_r;
  assign async_write = async_write_r;
  assign addr_bus    = addr_oe_r ? cur_addr_r : 16'hzzzz;
  assign data_bus    = data_oe_r ? cur_byte_s : 8'hzz;

endmodule

// File: tb/tb_k12a_mem_initiator.sv
// Self-checking bench: a per-cycle expected bus timeline is built from the
// access rules for every request and compared against the DUT each cycle.
module tb_k12a_mem_initiator;
  import k12a_mem_pkg::*;

  localparam int R = 2, S = 1, W = 2, H = 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_wide = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        req_ready, rsp_valid, mem_enable, async_write;
  logic [15:0] rsp_rdata;
  mem_mode_t   mem_mode;
  wire  [15:0] addr_bus;
  wire  [7:0]  data_bus;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic       mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  typedef struct {
    bit          en;
    bit          wmode;
    bit          aw;
    bit          rdy;
    bit          rv;
    logic [15:0] addr;
    logic [15:0] rd;
    logic [7:0]  wd;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] last_rsp = 16'd0;

  k12a_mem_initiator #(
    .READ_CYCLES(R), .SETUP_CYCLES(S), .STROBE_CYCLES(W), .HOLD_CYCLES(H)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_enable(mem_enable), .mem_mode(mem_mode), .async_write(async_write),
    .addr_bus(addr_bus), .data_bus(data_bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    case (a)
      16'h1234: init_byte = 8'hA5;
      16'h7FFF: init_byte = 8'h11;
      16'h8000: init_byte = 8'h22;
      16'h4000: init_byte = 8'h77;
      default:  init_byte = a[7:0] ^ {a[14:8], a[15]} ^ 8'h3C;
    endcase
  endfunction

  // Responder: drives read data, captures writes while strobed.
  assign data_bus = (mem_enable && mem_mode == MEM_MODE_READ) ? mem[addr_bus] : 8'hzz;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(16'(i));
      mem_ready <= 1'b1;
    end else if (mem_enable && mem_mode == MEM_MODE_WRITE && async_write) begin
      mem[addr_bus] <= data_bus;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic push(input bit en, input bit wmode, input bit aw, input bit rdy, input bit rv,
                      input logic [15:0] addr, input logic [15:0] rd, input logic [7:0] wd,
                      input int n);
    exp_t e;
    e = '{en: en, wmode: wmode, aw: aw, rdy: rdy, rv: rv, addr: addr, rd: rd, wd: wd};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Expected cycle-by-cycle behaviour of one request, starting at its accept cycle.
  task automatic model_issue(input bit wr, input bit wide, input logic [15:0] addr,
                             input logic [15:0] wdata);
    logic [15:0] a;
    logic [15:0] rsp;
    logic [7:0]  b8;
    rsp = 16'd0;
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, last_rsp, 8'd0, 1);
    for (int b = 0; b < (wide ? 2 : 1); b++) begin
      a = addr + 16'(b);
      if (b == 1) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, last_rsp, 8'd0, 1);
      if (wr) begin
        b8 = (b == 1) ? wdata[15:8] : wdata[7:0];
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, last_rsp, b8, S);
        push(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, a, last_rsp, b8, W);
        push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, last_rsp, b8, H);
        ref_mem[a] = b8;
      end else begin
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, last_rsp, 8'd0, R);
        if (b == 1) rsp[15:8] = ref_mem[a];
        else        rsp[7:0]  = ref_mem[a];
      end
    end
    if (wr) rsp = 16'd0;
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, rsp, 8'd0, 1);
    last_rsp = rsp;
  endtask

  // Per-cycle comparison against the expected timeline (idle when it is empty).
  always @(negedge clock) begin : compare
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{en: 1'b0, wmode: 1'b0, aw: 1'b0, rdy: 1'b1, rv: 1'b0,
                 addr: 16'd0, rd: last_rsp, wd: 8'd0};
      chk("req_ready",   {15'd0, req_ready},   {15'd0, e.rdy});
      chk("mem_enable",  {15'd0, mem_enable},  {15'd0, e.en});
      chk("mem_mode",    {15'd0, mem_mode},    {15'd0, e.wmode});
      chk("async_write", {15'd0, async_write}, {15'd0, e.aw});
      chk("rsp_valid",   {15'd0, rsp_valid},   {15'd0, e.rv});
      chk("rsp_rdata",   rsp_rdata,            e.rd);
      if (e.en)    chk("addr_bus", addr_bus, e.addr);
      if (e.wmode) chk("data_bus", {8'd0, data_bus}, {8'd0, e.wd});
    end
  end

  // Issue one request from just after a rising edge with the DUT idle.
  task automatic do_req(input bit wr, input bit wide, input logic [15:0] addr,
                        input logic [15:0] wdata, input bit hold,
                        output int lat, output logic [15:0] rdata);
    bit got;
    got = 1'b0;
    lat = 0;
    rdata = 16'd0;
    #1;
    req_write = wr; req_wide = wide; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    model_issue(wr, wide, addr, wdata);
    @(posedge clock);
    #1;
    if (!hold) req_valid = 1'b0;
    for (int k = 1; k <= 64 && !got; k++) begin
      @(negedge clock);
      if (rsp_valid) begin
        got = 1'b1;
        lat = k;
        rdata = rsp_rdata;
      end else begin
        {req_write, req_wide} = 2'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
      end
    end
    req_valid = 1'b0;
    if (!got) begin
      chk("rsp_timeout", 16'd0, 16'd1);
      finish_run();
    end
    @(posedge clock);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    finish_run();
  end

  initial begin : main
    int          lat;
    int          exp_lat;
    logic [15:0] rd;
    bit          wr, wide, hold;
    logic [15:0] addr, wdata;

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));

    #3 reset_n = 1'b0;
    #10;
    chk("rst_mem_enable",  {15'd0, mem_enable},  16'd0);
    chk("rst_async_write", {15'd0, async_write}, 16'd0);
    chk("rst_rsp_valid",   {15'd0, rsp_valid},   16'd0);
    chk("rst_rsp_rdata",   rsp_rdata,            16'd0);
    chk("rst_mem_mode",    {15'd0, mem_mode},    16'd0);
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    chk_en = 1'b1;

    do_req(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, lat, rd);
    chk("nr_latency", 16'(lat), 16'd3);
    chk("nr_rdata", rd, 16'h00A5);

    do_req(1'b1, 1'b0, 16'h8010, 16'h003C, 1'b0, lat, rd);
    chk("nw_latency", 16'(lat), 16'd5);
    chk("nw_mem", {8'd0, mem[16'h8010]}, 16'h003C);

    do_req(1'b0, 1'b1, 16'h7FFF, 16'h0000, 1'b0, lat, rd);
    chk("wr_latency", 16'(lat), 16'd6);
    chk("wr_rdata", rd, 16'h2211);

    do_req(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 1'b0, lat, rd);
    chk("ww_latency", 16'(lat), 16'd10);
    chk("ww_mem_ffff", {8'd0, mem[16'hFFFF]}, 16'h00EF);
    chk("ww_mem_0000", {8'd0, mem[16'h0000]}, 16'h00BE);

    // Reset in the middle of a write strobe: strobe drops at once, no response.
    chk_en = 1'b0;
    #1;
    req_write = 1'b1; req_wide = 1'b0; req_addr = 16'h4000; req_wdata = 16'h005A;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #2;
    chk("strobe_before_reset", {15'd0, async_write}, 16'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_async_write", {15'd0, async_write}, 16'd0);
    chk("mid_rst_mem_enable",  {15'd0, mem_enable},  16'd0);
    chk("mid_rst_mem_mode",    {15'd0, mem_mode},    16'd0);
    chk("mid_rst_rsp_rdata",   rsp_rdata,            16'd0);
    repeat (3) begin
      @(negedge clock);
      chk("mid_rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    end
    reset_n = 1'b1;
    exp_q.delete();
    last_rsp = 16'd0;
    @(posedge clock);
    chk_en = 1'b1;
    chk("aborted_write_mem", {8'd0, mem[16'h4000]}, 16'h0077);

    // Request held valid through the whole access must be taken only once.
    do_req(1'b0, 1'b0, 16'h4000, 16'h0000, 1'b1, lat, rd);
    chk("held_rdata", rd, 16'h0077);
    repeat (4) @(posedge clock);

    for (int n = 0; n < 80; n++) begin
      wr   = 1'($urandom);
      wide = 1'($urandom);
      hold = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       addr = 16'h7FFE + 16'($urandom_range(0, 2));
        1:       addr = 16'hFFFE + 16'($urandom_range(0, 2));
        default: addr = 16'h2000 + 16'($urandom_range(0, 15));
      endcase
      wdata = 16'($urandom);
      do_req(wr, wide, addr, wdata, hold, lat, rd);
      exp_lat = (wide ? 2 : 1) * (wr ? (S + W + H) : R) + (wide ? 1 : 0) + 1;
      chk("rand_latency", 16'(lat), 16'(exp_lat));
      repeat ($urandom_range(0, 3)) @(posedge clock);
    end

    repeat (3) @(posedge clock);
    chk("final_queue_empty", 16'(exp_q.size()), 16'd0);
    finish_run();
  end

endmodule
